// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller: state encoding, coordinate
// width, default screen geometry and a saturating score helper.
package pong_pkg;

  localparam int CW = 11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_MISS  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int DEF_SCREEN_W     = 800;
  localparam int DEF_SCREEN_H     = 600;
  localparam int DEF_BALL_SZ      = 8;
  localparam int DEF_PAD_W        = 80;
  localparam int DEF_PAD_Y        = 560;
  localparam int DEF_BALL_STEP    = 2;
  localparam int DEF_PAD_STEP     = 4;
  localparam int DEF_LIVES_INIT   = 3;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int SCORE_MAX        = 63;

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'(SCORE_MAX)) ? v : v + 6'd1;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_ball_step.sv
// One-frame ball motion: next position and direction per axis, plus paddle
// hit and bottom-wall miss detection. Purely combinational.
module ball_step
  import pong_pkg::*;
#(
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int BALL_SZ   = DEF_BALL_SZ,
  parameter int PAD_W     = DEF_PAD_W,
  parameter int PAD_Y     = DEF_PAD_Y,
  parameter int BALL_STEP = DEF_BALL_STEP
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic          dx_left,
  input  logic          dy_up,
  input  logic [CW-1:0] pad_x,
  output logic [CW-1:0] nx,
  output logic [CW-1:0] ny,
  output logic          ndx_left,
  output logic          ndy_up,
  output logic          hit,
  output logic          miss
);

  // One spare bit keeps every sum and compare free of wrap-around.
  localparam logic [11:0] STEP  = 12'(BALL_STEP);
  localparam logic [11:0] BSZ   = 12'(BALL_SZ);
  localparam logic [11:0] X_MAX = 12'(SCREEN_W - BALL_SZ);
  localparam logic [11:0] PADY  = 12'(PAD_Y);
  localparam logic [11:0] PADW  = 12'(PAD_W);
  localparam logic [11:0] SH    = 12'(SCREEN_H);

  logic [11:0] x12, y12, p12, x_inc, x_dec, y_inc, y_dec;

  assign x12   = {1'b0, x};
  assign y12   = {1'b0, y};
  assign p12   = {1'b0, pad_x};
  assign x_inc = x12 + STEP;
  assign x_dec = x12 - STEP;
  assign y_inc = y12 + STEP;
  assign y_dec = y12 - STEP;

  assign hit  = !dy_up && (y12 + BSZ <= PADY) && (y12 + BSZ + STEP >= PADY)
                && (x12 + BSZ > p12) && (x12 < p12 + PADW);
  assign miss = !dy_up && !hit && (y12 + BSZ + STEP >= SH);

  always_comb begin
    nx       = x;
    ndx_left = dx_left;
    if (!dx_left) begin
      if (x_inc >= X_MAX) begin
        nx       = CW'(X_MAX);
        ndx_left = 1'b1;
      end else begin
        nx = CW'(x_inc);
      end
    end else if (x12 <= STEP) begin
      nx       = '0;
      ndx_left = 1'b0;
    end else begin
      nx = CW'(x_dec);
    end

    ny     = y;
    ndy_up = dy_up;
    if (dy_up) begin
      if (y12 <= STEP) begin
        ny     = '0;
        ndy_up = 1'b0;
      end else begin
        ny = CW'(y_dec);
      end
    end else if (hit) begin
      ny     = CW'(PADY - BSZ);
      ndy_up = 1'b1;
    end else if (!miss) begin
      ny = CW'(y_inc);
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/miss/over FSM advancing ball, paddle, score
// and lives once per frame_tick. All outputs come straight from registers.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int BALL_SZ      = DEF_BALL_SZ,
  parameter int PAD_W        = DEF_PAD_W,
  parameter int PAD_Y        = DEF_PAD_Y,
  parameter int BALL_STEP    = DEF_BALL_STEP,
  parameter int PAD_STEP     = DEF_PAD_STEP,
  parameter int LIVES_INIT   = DEF_LIVES_INIT,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic        game_over,
  output logic [1:0]  lives,
  output logic [5:0]  score,
  output logic [5:0]  hiscore,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [10:0] pad_x,
  output logic [10:0] pad_y,
  output logic [2:0]  state
);

  localparam int          CNT_W   = $clog2(SERVE_FRAMES + 1);
  localparam logic [CW-1:0] BALL_X0 = CW'(SCREEN_W / 2 - BALL_SZ / 2);
  localparam logic [CW-1:0] BALL_Y0 = CW'(SCREEN_H / 2 - BALL_SZ / 2);
  localparam logic [CW-1:0] PAD_X0  = CW'((SCREEN_W - PAD_W) / 2);
  localparam logic [11:0]   PAD_MAX = 12'(SCREEN_W - PAD_W);
  localparam logic [11:0]   PSTEP   = 12'(PAD_STEP);
  localparam logic [1:0]    LIVES0  = 2'(LIVES_INIT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]     bx_q, bx_d, by_q, by_d, px_q, px_d;
  logic              dxl_q, dxl_d, dyu_q, dyu_d;
  logic [1:0]        lives_q, lives_d;
  logic [5:0]        score_q, score_d, hi_q, hi_d;
  logic              go_q, go_d;

  logic [CW-1:0]     step_x, step_y, pad_mv;
  logic              step_dxl, step_dyu, hit, miss, serve_done;
  logic [11:0]       pad_wide, pad_r;

  ball_step #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .BALL_SZ  (BALL_SZ),
    .PAD_W    (PAD_W),
    .PAD_Y    (PAD_Y),
    .BALL_STEP(BALL_STEP)
  ) u_ball_step (
    .x       (bx_q),
    .y       (by_q),
    .dx_left (dxl_q),
    .dy_up   (dyu_q),
    .pad_x   (px_q),
    .nx      (step_x),
    .ny      (step_y),
    .ndx_left(step_dxl),
    .ndy_up  (step_dyu),
    .hit     (hit),
    .miss    (miss)
  );

  assign pad_wide   = {1'b0, px_q};
  assign pad_r      = pad_wide + PSTEP;
  assign serve_done = (cnt_q == CNT_W'(SERVE_FRAMES - 1));

  always_comb begin
    pad_mv = px_q;
    if (btn_right && !btn_left)
      pad_mv = (pad_r > PAD_MAX) ? CW'(PAD_MAX) : CW'(pad_r);
    else if (btn_left && !btn_right)
      pad_mv = (pad_wide <= PSTEP) ? '0 : CW'(pad_wide - PSTEP);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SERVE;
      S_SERVE: if (frame_tick && serve_done) state_d = S_PLAY;
      S_PLAY:  if (frame_tick && miss) state_d = S_MISS;
      S_MISS:  state_d = (lives_q <= 2'd1) ? S_OVER : S_SERVE;
      S_OVER:  if (start) state_d = S_SERVE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dxl_d   = dxl_q;
    dyu_d   = dyu_q;
    px_d    = px_q;
    lives_d = lives_q;
    score_d = score_q;
    hi_d    = hi_q;
    go_d    = go_q;
    if (frame_tick && (state_q == S_SERVE || state_q == S_PLAY)) px_d = pad_mv;
    case (state_q)
      S_IDLE: if (start) cnt_d = '0;
      S_SERVE: if (frame_tick) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (serve_done) begin
          dxl_d = 1'b0;
          dyu_d = 1'b0;
        end
      end
      S_PLAY: if (frame_tick && !miss) begin
        bx_d  = step_x;
        by_d  = step_y;
        dxl_d = step_dxl;
        dyu_d = step_dyu;
        if (hit) score_d = sat_inc(score_q);
      end
      S_MISS: begin
        lives_d = lives_q - 2'd1;
        if (lives_q <= 2'd1) begin
          go_d = 1'b1;
          hi_d = (score_q > hi_q) ? score_q : hi_q;
        end else begin
          bx_d  = BALL_X0;
          by_d  = BALL_Y0;
          cnt_d = '0;
        end
      end
      S_OVER: if (start) begin
        score_d = '0;
        lives_d = LIVES0;
        bx_d    = BALL_X0;
        by_d    = BALL_Y0;
        go_d    = 1'b0;
        cnt_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      bx_q    <= BALL_X0;
      by_q    <= BALL_Y0;
      dxl_q   <= 1'b0;
      dyu_q   <= 1'b0;
      px_q    <= PAD_X0;
      lives_q <= LIVES0;
      score_q <= '0;
      hi_q    <= '0;
      go_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dxl_q   <= dxl_d;
      dyu_q   <= dyu_d;
      px_q    <= px_d;
      lives_q <= lives_d;
      score_q <= score_d;
      hi_q    <= hi_d;
      go_q    <= go_d;
    end
  end

  assign state     = state_q;
  assign game_over = go_q;
  assign lives     = lives_q;
  assign score     = score_q;
  assign hiscore   = hi_q;
  assign ball_x    = bx_q;
  assign ball_y    = by_q;
  assign pad_x     = px_q;
  assign pad_y     = CW'(PAD_Y);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench: two DUTs (default width and an 500-pixel screen) run the
// same stimulus against a behavioural model of the game rules.
module tb_pong_game_ctrl;

  logic clk, rst, frame_tick, start, btn_left, btn_right;

  logic        go0, go1;
  logic [1:0]  lv0, lv1;
  logic [5:0]  sc0, sc1, hi0, hi1;
  logic [10:0] bx0, by0, px0, py0, bx1, by1, px1, py1;
  logic [2:0]  st0, st1;

  pong_game_ctrl u_dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .btn_left(btn_left), .btn_right(btn_right),
    .game_over(go0), .lives(lv0), .score(sc0), .hiscore(hi0),
    .ball_x(bx0), .ball_y(by0), .pad_x(px0), .pad_y(py0), .state(st0)
  );

  pong_game_ctrl #(.SCREEN_W(500)) u_w500 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .btn_left(btn_left), .btn_right(btn_right),
    .game_over(go1), .lives(lv1), .score(sc1), .hiscore(hi1),
    .ball_x(bx1), .ball_y(by1), .pad_x(px1), .pad_y(py1), .state(st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: direction as +1/-1, phases by name-like constants.
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_MISS = 3, M_OVER = 4;

  typedef struct {
    int st, x, y, dx, dy, pad, cnt, score, lives, hi, go;
  } mdl_t;

  mdl_t m0, m1;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic mdl_t m_reset(input int sw);
    mdl_t m;
    m.st = M_IDLE; m.x = sw / 2 - 4; m.y = 296; m.dx = 1; m.dy = 1;
    m.pad = (sw - 80) / 2; m.cnt = 0; m.score = 0; m.lives = 3; m.hi = 0; m.go = 0;
    return m;
  endfunction

  function automatic int pad_move(input int p, input int sw, input bit l, input bit r);
    if (r && !l) return (p + 4 > sw - 80) ? sw - 80 : p + 4;
    if (l && !r) return (p - 4 < 0) ? 0 : p - 4;
    return p;
  endfunction

  function automatic mdl_t m_step(input mdl_t m, input int sw, input bit tk,
                                  input bit s, input bit l, input bit r);
    mdl_t n;
    bit   hit;
    n = m;
    case (m.st)
      M_IDLE: if (s) begin n.st = M_SERVE; n.cnt = 0; end
      M_SERVE: if (tk) begin
        n.pad = pad_move(m.pad, sw, l, r);
        n.cnt = m.cnt + 1;
        if (n.cnt == 60) begin n.st = M_PLAY; n.dx = 1; n.dy = 1; end
      end
      M_PLAY: if (tk) begin
        n.pad = pad_move(m.pad, sw, l, r);
        hit = (m.dy > 0) && (m.y + 8 <= 560) && (m.y + 10 >= 560)
              && (m.x + 8 > m.pad) && (m.x < m.pad + 80);
        if (m.dy > 0 && !hit && m.y + 10 >= 600) begin
          n.st = M_MISS;
        end else begin
          if (m.dx > 0) begin
            if (m.x + 2 >= sw - 8) begin n.x = sw - 8; n.dx = -1; end
            else n.x = m.x + 2;
          end else begin
            if (m.x <= 2) begin n.x = 0; n.dx = 1; end
            else n.x = m.x - 2;
          end
          if (m.dy < 0) begin
            if (m.y <= 2) begin n.y = 0; n.dy = 1; end
            else n.y = m.y - 2;
          end else if (hit) begin
            n.y = 552; n.dy = -1;
            n.score = (m.score < 63) ? m.score + 1 : 63;
          end else begin
            n.y = m.y + 2;
          end
        end
      end
      M_MISS: begin
        n.lives = m.lives - 1;
        if (n.lives == 0) begin
          n.st = M_OVER; n.go = 1;
          n.hi = (m.score > m.hi) ? m.score : m.hi;
        end else begin
          n.st = M_SERVE; n.cnt = 0; n.x = sw / 2 - 4; n.y = 296;
        end
      end
      M_OVER: if (s) begin
        n.st = M_SERVE; n.cnt = 0; n.score = 0; n.lives = 3; n.go = 0;
        n.x = sw / 2 - 4; n.y = 296;
      end
      default: ;
    endcase
    return n;
  endfunction

  task automatic cmp_one(input string p, input mdl_t m, input int st, input int bx,
                         input int by, input int px, input int py, input int lv,
                         input int sc, input int hi, input int go);
    check({p, ".state"}, st, m.st);
    check({p, ".ball_x"}, bx, m.x);
    check({p, ".ball_y"}, by, m.y);
    check({p, ".pad_x"}, px, m.pad);
    check({p, ".pad_y"}, py, 560);
    check({p, ".lives"}, lv, m.lives);
    check({p, ".score"}, sc, m.score);
    check({p, ".hiscore"}, hi, m.hi);
    check({p, ".game_over"}, go, m.go);
  endtask

  task automatic cmp_all();
    cmp_one("w800", m0, st0, bx0, by0, px0, py0, lv0, sc0, hi0, go0);
    cmp_one("w500", m1, st1, bx1, by1, px1, py1, lv1, sc1, hi1, go1);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare after it.
  task automatic cyc(input bit tk, input bit s, input bit l, input bit r);
    frame_tick = tk; start = s; btn_left = l; btn_right = r;
    @(posedge clk);
    m0 = m_step(m0, 800, tk, s, l, r);
    m1 = m_step(m1, 500, tk, s, l, r);
    #1;
    cmp_all();
  endtask

  task automatic tick(input bit l, input bit r);
    cyc(1'b1, 1'b0, l, r);
    cyc(1'b0, 1'b0, l, r);
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_tick = 1'b0; start = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m0 = m_reset(800);
    m1 = m_reset(500);
    cmp_all();
  endtask

  initial begin
    int k;
    rst = 1'b1; frame_tick = 1'b0; start = 1'b0; btn_left = 1'b0; btn_right = 1'b0;

    // Reset state and a lone tick in IDLE
    do_reset();
    check("rst_state", st0, 0);
    check("rst_ball_x", bx0, 396);
    check("rst_ball_y", by0, 296);
    check("rst_pad_x", px0, 360);
    check("rst_lives", lv0, 3);
    check("rst_w500_ball_x", bx1, 246);
    tick(1'b0, 1'b0);
    check("idle_tick_state", st0, 0);
    check("idle_tick_ball_x", bx0, 396);

    // Serve, play, paddle clamp and hit; right-wall bounce on the narrow screen
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("start_serve", st0, 1);
    for (int i = 1; i <= 189; i++) begin
      tick(1'b0, i <= 70);
      if (i == 60)  check("serve_to_play", st0, 2);
      if (i == 61)  begin check("play1_x", bx0, 398); check("play1_y", by0, 298); end
      if (i == 70)  check("pad_after_70", px0, 640);
      if (i == 183) begin check("w500_wall_x", bx1, 492); check("w500_state", st1, 2); end
      if (i == 184) check("w500_back_x", bx1, 490);
      if (i == 188) begin
        check("hit_x", bx0, 652); check("hit_y", by0, 552); check("hit_score", sc0, 1);
      end
      if (i == 189) check("after_hit_y_up", by0, 550);
    end

    // Miss with no paddle under the ball, then run out of lives
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 207; i++) tick(1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("miss_state", st0, 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("miss_reserve", st0, 1);
    check("miss_lives", lv0, 2);
    check("miss_ball_x", bx0, 396);
    check("miss_ball_y", by0, 296);
    k = 0;
    while (!go0 && k < 1000) begin
      tick(1'b0, 1'b0);
      k++;
    end
    check("over_reached", go0, 1);
    check("over_state", st0, 4);
    check("over_hiscore", hi0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("restart_state", st0, 1);
    check("restart_lives", lv0, 3);
    check("restart_score", sc0, 0);
    check("restart_go", go0, 0);

    // Randomised play against the model
    do_reset();
    for (int i = 0; i < 6000; i++)
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 149) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0);

    // Asynchronous reset in the middle of play
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 65; i++) tick(1'b0, 1'b1);
    check("pre_rst_play", st0, 2);
    #2 rst = 1'b1;
    #1;
    check("arst_state", st0, 0);
    check("arst_ball_x", bx0, 396);
    check("arst_ball_y", by0, 296);
    check("arst_pad_x", px0, 360);
    check("arst_lives", lv0, 3);
    check("arst_score", sc0, 0);
    check("arst_hiscore", hi0, 0);
    check("arst_go", go0, 0);
    m0 = m_reset(800);
    m1 = m_reset(500);
    @(posedge clk);
    #1 rst = 1'b0;
    cmp_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
